// File: rtl/bcd_down_timer.sv
// BCD down-counter timer with load/start/stop control and a done pulse at zero.
// Optional BCD_TIMER_AUTO_RELOAD_EN: on expiry, reload from the last accepted load.
module bcd_down_timer #(
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    tick,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  input  logic                    start,
  input  logic                    stop,
  output logic [4*NUM_DIGITS-1:0] Q,
  output logic                    running,
  output logic                    done,
  output logic                    load_err
);

  localparam int unsigned W = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {StIdle, StRun, StExpired} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   q_q, q_d;
  logic           running_q, running_d;
  logic           done_q, done_d;
  logic           load_err_q, load_err_d;
  logic           load_ok;
  logic [W-1:0]   q_dec;
  logic           borrow;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
  logic [W-1:0]   reload_q, reload_d;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      q_q        <= '0;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
      reload_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      q_q        <= q_d;
      running_q  <= running_d;
      done_q     <= done_d;
      load_err_q <= load_err_d;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
      reload_q   <= reload_d;
`endif
    end
  end

  // Preset is accepted only when every digit is a legal BCD value.
  always_comb begin
    load_ok = 1'b1;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (load_val[4*i +: 4] > 4'd9) load_ok = 1'b0;
    end
  end

  // Ripple-borrow BCD decrement: a zero digit becomes 9 and keeps borrowing.
  always_comb begin
    q_dec  = q_q;
    borrow = 1'b1;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (borrow) begin
        if (q_q[4*i +: 4] == 4'd0) begin
          q_dec[4*i +: 4] = 4'd9;
        end else begin
          q_dec[4*i +: 4] = q_q[4*i +: 4] - 4'd1;
          borrow          = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    q_d        = q_q;
    done_d     = 1'b0;
    load_err_d = 1'b0;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
    reload_d   = reload_q;
`endif
    if (load) begin
      if (load_ok) begin
        q_d     = load_val;
        state_d = StIdle;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
        reload_d = load_val;
`endif
      end else begin
        load_err_d = 1'b1;
      end
    end else if (stop) begin
      if (state_q == StRun) state_d = StIdle;
    end else if (start) begin
      if (state_q == StIdle && q_q != '0) state_d = StRun;
    end else if (tick && state_q == StRun) begin
      if (q_q == W'(1)) begin
        // Gate on done_q so a reload of 1 cannot produce back-to-back pulses.
        done_d = !done_q;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
        if (reload_q != '0) begin
          q_d = reload_q;
        end else begin
          q_d     = '0;
          state_d = StExpired;
        end
`else
        q_d     = '0;
        state_d = StExpired;
`endif
      end else begin
        q_d = q_dec;
      end
    end
    running_d = (state_d == StRun);
  end

  always_comb begin
    Q        = q_q;
    running  = running_q;
    done     = done_q;
    load_err = load_err_q;
  end

endmodule

// File: tb/tb_bcd_down_timer.sv
// Directed self-checking bench for bcd_down_timer (default 4 digits).
module tb_bcd_down_timer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        tick, load, start, stop;
  logic [15:0] load_val;
  logic [15:0] Q;
  logic        running, done, load_err;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  bcd_down_timer #(.NUM_DIGITS(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .tick     (tick),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .stop     (stop),
    .Q        (Q),
    .running  (running),
    .done     (done),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_start(input logic [15:0] val);
    load = 1'b1; load_val = val; step();
    load = 1'b0; start = 1'b1; step();
    start = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; tick = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0; load_val = '0;
    step(); step();
    check("rst_q", Q, 16'h0000);
    check("rst_running", running, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_load_err", load_err, 1'b0);
    reset_n = 1'b1;

    // Wrap/borrow across three digits
    load = 1'b1; load_val = 16'h1000; step(); load = 1'b0;
    check("load_q", Q, 16'h1000);
    check("load_idle", running, 1'b0);
    start = 1'b1; step(); start = 1'b0;
    check("start_run", running, 1'b1);
    tick = 1'b1; step(); tick = 1'b0;
    check("wrap_q", Q, 16'h0999);
    check("wrap_running", running, 1'b1);
    check("wrap_done", done, 1'b0);
    step();
    check("no_tick_hold", Q, 16'h0999);
    tick = 1'b1; step(); tick = 1'b0;
    check("dec_q", Q, 16'h0998);

`ifdef BCD_TIMER_AUTO_RELOAD_EN
    load_start(16'h0002);
    tick = 1'b1;
    step(); check("ar_q1", Q, 16'h0001); check("ar_done1", done, 1'b0);
    step(); check("ar_q2", Q, 16'h0002); check("ar_done2", done, 1'b1);
    check("ar_run2", running, 1'b1);
    step(); check("ar_q3", Q, 16'h0001); check("ar_done3", done, 1'b0);
    step(); check("ar_q4", Q, 16'h0002); check("ar_done4", done, 1'b1);
    check("ar_run4", running, 1'b1);
    tick = 1'b0;
    stop = 1'b1; step(); stop = 1'b0;
`else
    // Expiry
    load_start(16'h0003);
    tick = 1'b1;
    step(); check("exp_q2", Q, 16'h0002);
    step(); check("exp_q1", Q, 16'h0001); check("exp_done_early", done, 1'b0);
    step();
    check("exp_q0", Q, 16'h0000);
    check("exp_done", done, 1'b1);
    check("exp_running", running, 1'b0);
    step();
    check("exp_tick_hold", Q, 16'h0000);
    check("exp_done_once", done, 1'b0);
    tick = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    check("exp_start_q", Q, 16'h0000);
    check("exp_start_run", running, 1'b0);
`endif

    // Bad load while running
    load_start(16'h0042);
    check("bad_pre_run", running, 1'b1);
    load = 1'b1; load_val = 16'h00A5; step(); load = 1'b0;
    check("bad_err", load_err, 1'b1);
    check("bad_q", Q, 16'h0042);
    check("bad_running", running, 1'b1);
    step();
    check("bad_err_once", load_err, 1'b0);
    check("bad_q_hold", Q, 16'h0042);

    // Priority: stop over tick, then start over tick
    load_start(16'h0005);
    stop = 1'b1; tick = 1'b1; step(); stop = 1'b0;
    check("pri_stop_q", Q, 16'h0005);
    check("pri_stop_idle", running, 1'b0);
    start = 1'b1; step(); start = 1'b0; tick = 1'b0;
    check("pri_start_run", running, 1'b1);
    check("pri_start_q", Q, 16'h0005);

    // Start with zero count is ignored
    load = 1'b1; load_val = 16'h0000; step(); load = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    check("zero_start", running, 1'b0);

    // Reset mid-run beats the expiring tick
    load_start(16'h0001);
    reset_n = 1'b0; tick = 1'b1; step();
    check("mid_rst_q", Q, 16'h0000);
    check("mid_rst_running", running, 1'b0);
    check("mid_rst_done", done, 1'b0);
    reset_n = 1'b1; step(); tick = 1'b0;
    check("mid_rst_done2", done, 1'b0);
    check("mid_rst_idle", running, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
